gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, unsigned, captured with start.
REQ-006 b_in  input  WIDTH  operand B, unsigned, captured with start.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  WIDTH  GCD value; holds until the next completion.
REQ-010 err  output  1  both operands zero; valid while done is high, else 0.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE; all outputs SHALL be registered or decoded from state (Moore).
REQ-012 IDLE, start=1 at an edge: the block SHALL load A<=a_in and B<=b_in and go to CALC; start=0: stay in IDLE.
REQ-013 CALC, at each edge, the first matching rule SHALL apply:
- A==0 or B==0: result<=A|B, go to DONE.
- A==B: result<=A, go to DONE.
- A>B: A<=A-B.
- Otherwise: B<=B-A.
REQ-014 Subtraction SHALL be WIDTH-bit unsigned; underflow is impossible given REQ-013 ordering.
REQ-015 Latency: with N subtractions, the state SHALL enter DONE at the (N+1)th edge after the start-sampling edge.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE at the next edge.
REQ-017 err SHALL be 1 during DONE only when both captured operands were 0; result is then 0.
REQ-018 start SHALL be ignored in CALC and DONE; no queuing; a_in and b_in are don't-care outside the capture edge.
REQ-019 In DONE the block SHALL NOT accept start; back-to-back operations therefore have a minimum start-to-start spacing of N+3 cycles.
REQ-020 result SHALL change only on entry to DONE.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, A=B=0, result=0, busy=0, done=0 and err=0 (and iter_count=0 when present).
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after rst_n rises, the first start SHALL behave as after power-up.

Configuration
REQ-023 Macro GCD_ITER_COUNT_EN:
- When defined, output iter_count (WIDTH bits) SHALL exist. It clears at the capture edge and increments on each subtraction edge.
- Its value SHALL hold from DONE until the next capture, and SHALL equal N exactly. The worst case, 2^WIDTH-2, fits without saturation.
- When undefined, the port and its counter SHALL be absent.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-024 WIDTH=16, a=143, b=72 -> done 73 cycles after the start edge; result=1; err=0; iter_count=72.
REQ-025 a=12, b=18 -> done 3 cycles after start; result=6; iter_count=2. a=7, b=7 -> done after 1 cycle; result=7; iter_count=0.
REQ-026 a=0, b=5 -> result=5, err=0, after 1 cycle. a=0, b=0 -> result=0 with err=1 during the done cycle.
REQ-027 start re-pulsed with a=9, b=3 during CALC of (143,72) -> ignored; result=1. Then a new start after return to IDLE -> result=3.
REQ-028 rst_n pulsed low mid-CALC of (143,72) -> outputs 0 immediately and no done pulse. A subsequent (48,36) -> result=12 after 4 cycles.
REQ-029 WIDTH=8, a=255, b=1 -> iter_count=254; done 255 cycles after start; result=1.

Source files
------------

// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
//
// Purpose:
//   Computes the greatest common divisor of two unsigned WIDTH-bit operands.
//   It uses the subtraction form of Euclid's algorithm, with one subtraction
//   per clock cycle. A three-state Moore FSM (IDLE -> CALC -> DONE -> IDLE)
//   sequences the operation.
//
// Parameters:
//   WIDTH       operand / result width in bits (legal range 2..32, default 16)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   start       operation request, sampled only while idle
//   a_in, b_in  operands, captured on the edge that accepts start
//   busy        high whenever the FSM is not idle
//   done        one-cycle completion pulse
//   result      GCD value, held until the next completion
//   err         both operands were zero; only asserted alongside done
//   iter_count  number of subtractions performed (GCD_ITER_COUNT_EN builds only)
//
// Configuration:
//   `define GCD_ITER_COUNT_EN to add the iter_count output and its counter.
// -----------------------------------------------------------------------------
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_reg;
`endif

    logic a_zero;
    logic b_zero;
    logic a_gt_b;
    logic a_eq_b;

    assign a_zero = (a_reg == '0);
    assign b_zero = (b_reg == '0);
    assign a_gt_b = (a_reg > b_reg);
    assign a_eq_b = (a_reg == b_reg);

    // The outputs are registered alongside the state. They change on the same
    // edges as the state, so they are equivalent to a decode of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            iter_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
`ifdef GCD_ITER_COUNT_EN
                        iter_reg  <= '0;
`endif
                    end
                end

                CALC: begin
                    if (a_zero || b_zero) begin
                        // A zero operand terminates immediately. Subtraction
                        // never produces two zeros, so both registers are zero
                        // here only when both captured operands were zero.
                        result_reg <= a_reg | b_reg;
                        err_reg    <= a_zero && b_zero;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else if (a_eq_b) begin
                        result_reg <= a_reg;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else if (a_gt_b) begin
                        // The ordering of the tests guarantees there is no underflow.
                        a_reg      <= a_reg - b_reg;
`ifdef GCD_ITER_COUNT_EN
                        iter_reg   <= iter_reg + WIDTH'(1);
`endif
                    end else begin
                        b_reg      <= b_reg - a_reg;
`ifdef GCD_ITER_COUNT_EN
                        iter_reg   <= iter_reg + WIDTH'(1);
`endif
                    end
                end

                DONE: begin
                    // start is deliberately not sampled here: the FSM always
                    // passes through IDLE before it accepts the next request.
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign err    = err_reg;
`ifdef GCD_ITER_COUNT_EN
    assign iter_count = iter_reg;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_engine
//
// Self-checking bench for gcd_engine. It drives a WIDTH=16 instance and a
// WIDTH=8 instance from one clock. The reference model is Euclid's division
// algorithm. The model derives the subtraction count from the sum of the
// quotients: stopping at equality removes one subtraction.
// -----------------------------------------------------------------------------
module tb_gcd_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16, err16;
    logic [15:0] result16;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, err8;
    logic [7:0]  result8;

`ifdef GCD_ITER_COUNT_EN
    logic [15:0] iter16;
    logic [7:0]  iter8;
`endif

    int checks = 0;
    int errors = 0;

    gcd_engine #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a_in       (a16),
        .b_in       (b16),
        .busy       (busy16),
        .done       (done16),
        .result     (result16),
        .err        (err16)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count (iter16)
`endif
    );

    gcd_engine #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy       (busy8),
        .done       (done8),
        .result     (result8),
        .err        (err8)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count (iter8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: GCD by Euclid's division. Subtractions = sum of quotients - 1.
    task automatic ref_gcd(input int unsigned a, input int unsigned b,
                           output int unsigned g, output int unsigned n, output bit e);
        int unsigned x, y, r;
        e = (a == 0) && (b == 0);
        n = 0;
        if (a == 0 || b == 0) begin
            g = a | b;
        end else begin
            x = a;
            y = b;
            while (y != 0) begin
                n += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            n -= 1;
        end
    endtask

    task automatic drive(input bit w8, input logic s, input int unsigned a, input int unsigned b);
        if (w8) begin
            start8 = s;
            a8 = a[7:0];
            b8 = b[7:0];
        end else begin
            start16 = s;
            a16 = a[15:0];
            b16 = b[15:0];
        end
    endtask

    function automatic logic [31:0] cur_done(input bit w8);
        return w8 ? 32'(done8) : 32'(done16);
    endfunction
    function automatic logic [31:0] cur_busy(input bit w8);
        return w8 ? 32'(busy8) : 32'(busy16);
    endfunction
    function automatic logic [31:0] cur_result(input bit w8);
        return w8 ? 32'(result8) : 32'(result16);
    endfunction
    function automatic logic [31:0] cur_err(input bit w8);
        return w8 ? 32'(err8) : 32'(err16);
    endfunction
`ifdef GCD_ITER_COUNT_EN
    function automatic logic [31:0] cur_iter(input bit w8);
        return w8 ? 32'(iter8) : 32'(iter16);
    endfunction
`endif

    // One full operation. When repulse_at is nonzero, start is re-asserted
    // with (9,3) for one cycle at that CALC cycle, and the engine must ignore it.
    task automatic run_op(input bit w8, input int unsigned a, input int unsigned b,
                          input int repulse_at);
        int unsigned g, n;
        bit          e;
        int          cycles;
        bit          seen;
        logic [31:0] res_hold;
        ref_gcd(a, b, g, n, e);
        @(negedge clk);
        drive(w8, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, 0, 0);
        check("busy_after_start", cur_busy(w8), 32'd1);
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cur_done(w8) == 32'd1) seen = 1'b1;
            else if (repulse_at != 0 && cycles == repulse_at) drive(w8, 1'b1, 9, 3);
            else drive(w8, 1'b0, 0, 0);
        end
        drive(w8, 1'b0, 0, 0);
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cycles), n + 1);
        check("result", cur_result(w8), g);
        check("err", cur_err(w8), 32'(e));
        check("busy_in_done", cur_busy(w8), 32'd1);
`ifdef GCD_ITER_COUNT_EN
        check("iter_count", cur_iter(w8), n);
`endif
        res_hold = cur_result(w8);
        @(posedge clk);
        #1;
        check("done_one_cycle", cur_done(w8), 32'd0);
        check("busy_after_done", cur_busy(w8), 32'd0);
        check("err_after_done", cur_err(w8), 32'd0);
        check("result_hold", cur_result(w8), res_hold);
`ifdef GCD_ITER_COUNT_EN
        check("iter_hold", cur_iter(w8), n);
`endif
        $display("op w=%0d a=%0d b=%0d -> result=%0d err=%0d cycles=%0d (exp gcd=%0d n=%0d)",
                 w8 ? 8 : 16, a, b, cur_result(w8), cur_err(w8), cycles, g, n);
    endtask

    initial begin
        int done_pulses;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        #12;
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_result", 32'(result16), 32'd0);
        check("rst_err", 32'(err16), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter", 32'(iter16), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", 32'(busy16), 32'd0);

        // Directed cases from the requirement list.
        run_op(1'b0, 143, 72, 0);
        run_op(1'b0, 12, 18, 0);
        run_op(1'b0, 7, 7, 0);
        run_op(1'b0, 0, 5, 0);
        run_op(1'b0, 0, 0, 0);
        run_op(1'b0, 143, 72, 10);   // the re-pulse of (9,3) must be ignored
        run_op(1'b0, 9, 3, 0);

        // Reset asserted in the middle of CALC.
        @(negedge clk);
        drive(1'b0, 1'b1, 143, 72);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0, 0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy16), 32'd0);
        check("midrst_done", 32'(done16), 32'd0);
        check("midrst_result", 32'(result16), 32'd0);
        check("midrst_err", 32'(err16), 32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("midrst_iter", 32'(iter16), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        done_pulses = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done16) done_pulses++;
        end
        check("midrst_no_done", 32'(done_pulses), 32'd0);
        $display("reset mid-CALC: done pulses afterwards=%0d", done_pulses);
        run_op(1'b0, 48, 36, 0);

        // Narrow instance, worst-case style operands.
        run_op(1'b1, 255, 1, 0);
        run_op(1'b1, 1, 255, 0);

        // Randomized operands on both widths, with zeros mixed in.
        for (int i = 0; i < 12; i++) begin
            int unsigned ra, rb;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ra = 0;
            run_op(1'b1, ra, rb, 0);
        end
        for (int i = 0; i < 20; i++) begin
            int unsigned ra, rb, k;
            k  = $urandom_range(1, 40);
            ra = k * $urandom_range(0, 30);
            rb = k * $urandom_range(0, 30);
            if ($urandom_range(0, 9) == 0) rb = 0;
            run_op(1'b0, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
